// File: rtl/dmem_hs.sv
// Handshaked data memory with per-lane write masks, programmable wait states
// and an optional zero-fill sequence after reset. One access in flight at a time.
module dmem_hs #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int LANE_W     = 4,
  parameter int WAIT       = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/LANE_W-1:0]   req_mask,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       busy
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          wcnt;
  logic                accept;
  logic [DATA_W-1:0]   acc_word;

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [LANES-1:0]  m
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < LANES; k++)
      if (m[k]) r[k*LANE_W +: LANE_W] = new_w[k*LANE_W +: LANE_W];
    return r;
  endfunction

  // req_ready is high exactly when the FSM sits in IDLE
  assign accept = req_ready && req_valid;

  always_comb begin
    acc_word = mem[req_addr];
    if (req_we) acc_word = lane_merge(mem[req_addr], req_wdata, req_mask);
  end

  // Storage array: zero-fill during CLEAR, masked write at acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR)
        mem[cnt] <= '0;
      else if (accept && req_we)
        mem[req_addr] <= acc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q <= req_addr;
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= (INIT_CLEAR == 0);
      busy      <= (INIT_CLEAR != 0);
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {ADDR_W{1'b1}}) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (WAIT > 0) begin
              state <= S_WAIT;
              wcnt  <= WAIT_INIT;
            end else begin
              // Zero-wait: the response word already carries the write merged this edge
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= acc_word;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= mem[addr_q];
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Directed bench for dmem_hs: vector table on the default build plus
// hand-written reset, clear, backpressure and wait-state sequences.
module tb_dmem_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we, rsp_ready;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic [1:0] req_mask;
  logic       req_ready, rsp_valid, busy;
  logic [7:0] rsp_rdata;

  logic       b_req_valid, b_req_we, b_rsp_ready;
  logic [3:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic [1:0] b_req_mask;
  logic       b0_req_ready, b0_rsp_valid, b0_busy;
  logic [7:0] b0_rsp_rdata;
  logic       b3_req_ready, b3_rsp_valid, b3_busy;
  logic [7:0] b3_rsp_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_hs #(.DATA_W(8), .ADDR_W(4), .LANE_W(4), .WAIT(1), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .busy(busy));

  dmem_hs #(.DATA_W(8), .ADDR_W(4), .LANE_W(4), .WAIT(0), .INIT_CLEAR(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b0_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_mask(b_req_mask),
    .rsp_valid(b0_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b0_rsp_rdata), .busy(b0_busy));

  dmem_hs #(.DATA_W(8), .ADDR_W(4), .LANE_W(4), .WAIT(3), .INIT_CLEAR(1)) dut_w3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b3_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_mask(b_req_mask),
    .rsp_valid(b3_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b3_rsp_rdata), .busy(b3_busy));

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [1:0] m;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Issue one access on the WAIT=1 build; lat counts edges from acceptance to rsp_valid
  task automatic access(input logic we, input logic [3:0] a, input logic [7:0] wd,
                        input logic [1:0] m, output logic [7:0] rd, output int lat);
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; req_mask = m; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata;
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic clear_wait(input string nm);
    int n;
    int bad;
    n = 0; bad = 0;
    while (busy && n < 40) begin
      if (req_ready || rsp_valid) bad++;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_busy_cycles"}, n, 16);
    chk({nm, "_ready_low"}, bad, 0);
    chk({nm, "_ready_after"}, {31'd0, req_ready}, 1);
  endtask

  // Same request to the WAIT=0 and WAIT=3 builds, watching both responses
  task automatic b_access(input logic we, input logic [3:0] a, input logic [7:0] wd,
                          input logic [1:0] m, output logic [7:0] rd0, output logic [7:0] rd3,
                          output int lat0, output int lat3);
    rd0 = '0; rd3 = '0; lat0 = 0; lat3 = 0;
    @(negedge clk);
    b_req_we = we; b_req_addr = a; b_req_wdata = wd; b_req_mask = m; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (b0_rsp_valid && lat0 == 0) begin lat0 = c; rd0 = b0_rsp_rdata; end
      if (b3_rsp_valid && lat3 == 0) begin lat3 = c; rd3 = b3_rsp_rdata; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd, rd0, rd3;
    int lat, lat0, lat3, bad;

    vecs[0]  = '{1'b0, 4'h3, 8'h00, 2'b00, 8'h00};
    vecs[1]  = '{1'b1, 4'h5, 8'h3C, 2'b11, 8'h3C};
    vecs[2]  = '{1'b0, 4'h5, 8'h00, 2'b00, 8'h3C};
    vecs[3]  = '{1'b1, 4'h2, 8'hFF, 2'b11, 8'hFF};
    vecs[4]  = '{1'b1, 4'h2, 8'h12, 2'b01, 8'hF2};
    vecs[5]  = '{1'b0, 4'h2, 8'h00, 2'b00, 8'hF2};
    vecs[6]  = '{1'b1, 4'h2, 8'h00, 2'b00, 8'hF2};
    vecs[7]  = '{1'b1, 4'h2, 8'hAB, 2'b10, 8'hA2};
    vecs[8]  = '{1'b1, 4'hF, 8'h77, 2'b11, 8'h77};
    vecs[9]  = '{1'b0, 4'hF, 8'h00, 2'b00, 8'h77};
    vecs[10] = '{1'b1, 4'h3, 8'hA5, 2'b11, 8'hA5};
    vecs[11] = '{1'b0, 4'h0, 8'h00, 2'b00, 8'h00};

    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_mask = '0;
    b_rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
    chk("rst_noclear_ready", {31'd0, b0_req_ready}, 1);
    chk("rst_noclear_busy", {31'd0, b0_busy}, 0);
    chk("rst_clear_w3_busy", {31'd0, b3_busy}, 1);
    rst = 1'b0;
    clear_wait("init_clear");

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].m, rd, lat);
      chk($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), lat, 2);
    end

    // Backpressure: response held while a stray write request is offered
    rsp_ready = 1'b0;
    access(1'b0, 4'h5, 8'h00, 2'b00, rd, lat);
    chk("bp_rdata", {24'd0, rd}, 32'h3C);
    chk("bp_latency", lat, 2);
    req_we = 1'b1; req_addr = 4'h5; req_wdata = 8'h00; req_mask = 2'b11; req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== 8'h3C || req_ready) bad++;
      if (i == 1) req_valid = 1'b0;
    end
    chk("bp_stall_hold", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, rsp_valid}, 0);
    chk("bp_release_rdata", {24'd0, rsp_rdata}, 32'h3C);
    chk("bp_release_ready", {31'd0, req_ready}, 1);
    access(1'b0, 4'h5, 8'h00, 2'b00, rd, lat);
    chk("bp_stray_ignored", {24'd0, rd}, 32'h3C);

    // Reset pulse zero-fills the array
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_wait("reset_clear");
    access(1'b0, 4'h3, 8'h00, 2'b00, rd, lat);
    chk("clear_addr3", {24'd0, rd}, 0);
    access(1'b0, 4'hF, 8'h00, 2'b00, rd, lat);
    chk("clear_addr15", {24'd0, rd}, 0);

    // Reset during CLEAR restarts the fill from address 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("restart_busy", {31'd0, busy}, 1);
    clear_wait("restart_clear");

    // Reset while an accepted write waits for its response
    access(1'b1, 4'h8, 8'h66, 2'b11, rd, lat);
    chk("pre_abort_rdata", {24'd0, rd}, 32'h66);
    @(negedge clk);
    req_we = 1'b1; req_addr = 4'h7; req_wdata = 8'h5A; req_mask = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_wait", {31'd0, req_ready | rsp_valid}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("abort_rsp_rdata", {24'd0, rsp_rdata}, 0);
    chk("abort_busy", {31'd0, busy}, 1);
    clear_wait("abort_clear");
    access(1'b0, 4'h7, 8'h00, 2'b00, rd, lat);
    chk("abort_addr7_cleared", {24'd0, rd}, 0);

    // WAIT=0 and WAIT=3 builds
    b_access(1'b1, 4'h0, 8'h00, 2'b11, rd0, rd3, lat0, lat3);
    chk("w0_write_latency", lat0, 1);
    chk("w3_write_latency", lat3, 4);
    b_access(1'b0, 4'h0, 8'h00, 2'b00, rd0, rd3, lat0, lat3);
    chk("w0_read_latency", lat0, 1);
    chk("w3_read_latency", lat3, 4);
    chk("w0_read_rdata", {24'd0, rd0}, 0);
    chk("w3_read_rdata", {24'd0, rd3}, 0);
    b_access(1'b1, 4'h0, 8'h5C, 2'b10, rd0, rd3, lat0, lat3);
    chk("w0_mask_rdata", {24'd0, rd0}, 32'h50);
    chk("w3_mask_rdata", {24'd0, rd3}, 32'h50);
    chk("w0_mask_latency", lat0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
